// File: rtl/ball_pkg.sv
// ----------------------------------------------------------------------------
// ball_pkg
// Shared types and constants for the ball collision logic.
//   NUM_BALLS    : number of ball objects tracked per collision source
//   ball_idx_t   : index of each ball inside the per-ball slot vectors
//   col_arm_st_t : arming state of the collision detector
//   ropeEnabled  : rope collisions are live in both GRACE and ARMED
// ----------------------------------------------------------------------------
package ball_pkg;

   localparam int NUM_BALLS = 3;

   typedef enum logic [1:0] {
      HUGE = 2'd0,
      BIG1 = 2'd1,
      BIG2 = 2'd2
   } ball_idx_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRACE = 2'd1,
      ARMED = 2'd2
   } col_arm_st_t;

   function automatic logic ropeEnabled(input col_arm_st_t st);
      return (st == GRACE) || (st == ARMED);
   endfunction

endpackage

// File: rtl/ball_collision_detector_if.sv
// ----------------------------------------------------------------------------
// ball_collision_detector_if
// Bundles the per-pixel drawing requests, frame/unit controls and the
// collision pulses exchanged with the ball collision detector.
//   master : drives drawing requests / controls, receives collision pulses
//   slave  : the detector itself
// ----------------------------------------------------------------------------
interface ball_collision_detector_if;

   logic startOfFrame;
   logic unitActive;
   logic ropeDrawingRequest;
   logic playerDrawingRequest;
   logic hugeBallDrawingRequest;
   logic bigBall1DrawingRequest;
   logic bigBall2DrawingRequest;

   logic col_rope_hugeBall;
   logic col_rope_bigBall1;
   logic col_rope_bigBall2;
   logic col_player_hugeBall;
   logic col_player_bigBall1;
   logic col_player_bigBall2;
   logic armed;

   modport master (
      output startOfFrame, unitActive,
      output ropeDrawingRequest, playerDrawingRequest,
      output hugeBallDrawingRequest, bigBall1DrawingRequest, bigBall2DrawingRequest,
      input  col_rope_hugeBall, col_rope_bigBall1, col_rope_bigBall2,
      input  col_player_hugeBall, col_player_bigBall1, col_player_bigBall2,
      input  armed
   );

   modport slave (
      input  startOfFrame, unitActive,
      input  ropeDrawingRequest, playerDrawingRequest,
      input  hugeBallDrawingRequest, bigBall1DrawingRequest, bigBall2DrawingRequest,
      output col_rope_hugeBall, col_rope_bigBall1, col_rope_bigBall2,
      output col_player_hugeBall, col_player_bigBall1, col_player_bigBall2,
      output armed
   );

endinterface

// File: rtl/ball_collision_detector_col_one_shot.sv
// ----------------------------------------------------------------------------
// col_one_shot
// One (object, ball) collision slot: emits a single registered pulse for the
// first enabled hit of a frame and then stays silent until cleared.
//   clk    : pixel clock
//   resetN : asynchronous active-low reset
//   clear  : start a new frame (forget that the slot already fired)
//   enable : slot allowed to fire
//   hit    : combinational overlap for the current pixel
//   pulse  : registered one-cycle collision pulse
// ----------------------------------------------------------------------------
module col_one_shot (
   input  logic clk,
   input  logic resetN,
   input  logic clear,
   input  logic enable,
   input  logic hit,
   output logic pulse
);

   logic firedReg, firedNext;
   logic pulseReg, pulseNext;
   logic liveHit;

   always_comb begin
      liveHit   = hit && enable;
      // A hit coinciding with clear belongs to the new frame, so it fires
      // regardless of the old fired flag.
      pulseNext = liveHit && (clear || !firedReg);
      firedNext = clear ? liveHit : (firedReg || liveHit);
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         firedReg <= 1'b0;
         pulseReg <= 1'b0;
      end else begin
         firedReg <= firedNext;
         pulseReg <= pulseNext;
      end
   end

   assign pulse = pulseReg;

endmodule

// File: rtl/ball_collision_detector.sv
// ----------------------------------------------------------------------------
// ball_collision_detector
// Produces at most one collision pulse per (rope|player, ball) pair per frame
// from the per-pixel drawing requests. An arming FSM keeps player hits
// suppressed for GRACE_FRAMES frames after the unit becomes active; rope hits
// are already live during that grace period.
//   clk    : pixel clock
//   resetN : asynchronous active-low reset
//   bus    : drawing requests, startOfFrame, unitActive in; col_* pulses and
//            armed out (all outputs registered)
// Parameters: GRACE_FRAMES (0..255), CNT_W (grace counter width)
// ----------------------------------------------------------------------------
module ball_collision_detector
   import ball_pkg::*;
#(
   parameter int GRACE_FRAMES = 60,
   parameter int CNT_W        = 8
) (
   input  logic                      clk,
   input  logic                      resetN,
   ball_collision_detector_if.slave  bus
);

   localparam logic [CNT_W-1:0] GRACE_LOAD = CNT_W'(GRACE_FRAMES);

   col_arm_st_t            stateReg;
   logic [CNT_W-1:0]       graceCntReg;
   logic                   armedReg;

   logic [NUM_BALLS-1:0]   ballReq;
   logic [NUM_BALLS-1:0]   ropePulse;
   logic [NUM_BALLS-1:0]   playerPulse;
   logic                   clearFlags;
   logic                   ropeEn;
   logic                   playerEn;

   assign ballReq[HUGE] = bus.hugeBallDrawingRequest;
   assign ballReq[BIG1] = bus.bigBall1DrawingRequest;
   assign ballReq[BIG2] = bus.bigBall2DrawingRequest;

   // unitActive is folded in combinationally so that the cycle it drops
   // already issues no pulse and wipes the frame flags.
   assign clearFlags = bus.startOfFrame || !bus.unitActive || (stateReg == IDLE);
   assign ropeEn     = bus.unitActive && ropeEnabled(stateReg);
   assign playerEn   = bus.unitActive && (stateReg == ARMED);

   generate
      for (genvar gi = 0; gi < NUM_BALLS; gi++) begin : gSlot
         col_one_shot uRope (
            .clk    (clk),
            .resetN (resetN),
            .clear  (clearFlags),
            .enable (ropeEn),
            .hit    (bus.ropeDrawingRequest && ballReq[gi]),
            .pulse  (ropePulse[gi])
         );

         col_one_shot uPlayer (
            .clk    (clk),
            .resetN (resetN),
            .clear  (clearFlags),
            .enable (playerEn),
            .hit    (bus.playerDrawingRequest && ballReq[gi]),
            .pulse  (playerPulse[gi])
         );
      end
   endgenerate

   // Arming FSM. The counter only decrements while non-zero, so it saturates
   // at 0; reaching 0 moves to ARMED on the following edge.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         stateReg    <= IDLE;
         graceCntReg <= '0;
         armedReg    <= 1'b0;
      end else begin
         case (stateReg)
            IDLE: begin
               armedReg <= 1'b0;
               if (bus.unitActive) begin
                  stateReg    <= GRACE;
                  graceCntReg <= GRACE_LOAD;
               end else begin
                  graceCntReg <= '0;
               end
            end
            GRACE: begin
               if (!bus.unitActive) begin
                  stateReg    <= IDLE;
                  graceCntReg <= '0;
                  armedReg    <= 1'b0;
               end else if (graceCntReg == '0) begin
                  stateReg <= ARMED;
                  armedReg <= 1'b1;
               end else if (bus.startOfFrame) begin
                  graceCntReg <= graceCntReg - 1'b1;
               end
            end
            ARMED: begin
               if (!bus.unitActive) begin
                  stateReg    <= IDLE;
                  graceCntReg <= '0;
                  armedReg    <= 1'b0;
               end
            end
            default: begin
               stateReg    <= IDLE;
               graceCntReg <= '0;
               armedReg    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.col_rope_hugeBall   = ropePulse[HUGE];
   assign bus.col_rope_bigBall1   = ropePulse[BIG1];
   assign bus.col_rope_bigBall2   = ropePulse[BIG2];
   assign bus.col_player_hugeBall = playerPulse[HUGE];
   assign bus.col_player_bigBall1 = playerPulse[BIG1];
   assign bus.col_player_bigBall2 = playerPulse[BIG2];
   assign bus.armed               = armedReg;

endmodule

// File: doc/ball_collision_detector.md
# ball_collision_detector

Producer of the per-ball collision events consumed by the ball controller. Samples the per-pixel drawing requests of the rope, the player and the three balls (huge, big1, big2) during the VGA scan. Emits at most one single-cycle collision pulse per (object, ball) pair per frame. Includes an arming state machine that suppresses player hits for a grace period after the unit becomes active.

## Interface
Parameters:
- GRACE_FRAMES, 60, number of frames player collisions are suppressed after activation; range 0..255
- CNT_W, 8, width of the grace-frame counter

Ports:
- clk  in  1  system clock (pixel clock domain)
- resetN  in  1  reset; one clock; reset is asynchronous and active-low
- startOfFrame  in  1  one-cycle pulse at the first pixel of each frame
- unitActive  in  1  level; game unit running
- ropeDrawingRequest  in  1  rope draws the current pixel
- playerDrawingRequest  in  1  player draws the current pixel
- hugeBallDrawingRequest, bigBall1DrawingRequest, bigBall2DrawingRequest  in  1 each  ball draws the current pixel
- col_rope_hugeBall, col_rope_bigBall1, col_rope_bigBall2  out  1 each  registered one-cycle rope-hit pulse
- col_player_hugeBall, col_player_bigBall1, col_player_bigBall2  out  1 each  registered one-cycle player-hit pulse
- armed  out  1  high when player collisions are enabled

## Operation
- Overlap is combinational per pixel, e.g. ropeDrawingRequest && hugeBallDrawingRequest.
- Six pair slots: rope×{huge, big1, big2} and player×{huge, big1, big2}. Each slot holds a per-frame "fired" flag.
- A slot pulses when overlap is true, its fired flag is 0, and the slot is enabled. The same edge sets fired.
- All fired flags clear on startOfFrame.
- If overlap coincides with startOfFrame, it belongs to the new frame: the flag clears and fires in the same cycle.
- Rope slots are enabled whenever the state is ARMED or GRACE.
- Player slots are enabled only in ARMED.
- Simultaneous overlaps on different slots in one pixel each pulse independently. Rope and player on the same ball both pulse.
- FSM states:
  - IDLE: all slots disabled, counter = 0. unitActive=1 → GRACE, counter loaded with GRACE_FRAMES.
  - GRACE: each startOfFrame decrements the counter. When counter == 0 → ARMED. GRACE_FRAMES=0 passes straight through GRACE in one cycle.
  - ARMED: steady state.
  - Any state: unitActive=0 → IDLE on the next edge. Fired flags clear and no pulses are issued.
- Counter saturates at 0 and never wraps.

## Timing
- Reset values: all col_* outputs 0, armed 0, FSM IDLE, counter 0, fired flags 0.
- Latency: overlap at edge N → pulse high during cycle N+1, for exactly one cycle.
- armed is registered. It rises the cycle after the counter reaches 0 in GRACE.
- Reset asserted mid-frame or mid-grace returns the block to IDLE immediately. No pulse is issued after reset is released until a new overlap occurs.
- A continuous overlap spanning several lines of one frame produces exactly one pulse. The same overlap in the next frame pulses again.

## Structure
- Shared package ball_pkg:
  - NUM_BALLS = 3
  - enum ball_idx_t {HUGE, BIG1, BIG2}
  - enum col_arm_st_t {IDLE, GRACE, ARMED}
- Sub-module col_one_shot: a single pair slot.
  - Inputs: clk, resetN, clear, enable, hit.
  - Output: registered pulse.
  - Instantiated six times, indexed by ball_idx_t.
- Top level holds the FSM and the grace counter.

## Test plan
- Reset, unitActive=1, GRACE_FRAMES=2. Issue 2 startOfFrame pulses → armed rises after the second. Player/huge overlap before that → no col_player_hugeBall.
- Armed. Rope/bigBall1 overlap held for 50 cycles within one frame → col_rope_bigBall1 high exactly 1 cycle, 1 cycle after the first overlap. Repeat in the next frame → one more pulse.
- Armed. Same pixel has rope, player and hugeBall → col_rope_hugeBall and col_player_hugeBall both pulse on the same cycle. No other outputs pulse.
- Overlap coincident with startOfFrame, after the previous frame already fired → pulse issued for the new frame.
- unitActive drops mid-frame with an overlap present → no pulses, armed=0 next cycle, FSM IDLE. Re-raising unitActive restarts a full grace period.
- resetN pulsed low during GRACE → all outputs 0 asynchronously, counter 0.
